weight_feed_sequencer: RTL

Parametrised weight-feeding microsequencer for the systolic convolution array. It generates BRAM read addresses and enables for one or more filters and tolerates a configurable BRAM read latency. It drives the weight shift-register chain so that every filter presents exactly DIM shifts: kernel_size data words followed by zero fill. It sequences multiple filters back-to-back or under an advance handshake, owns its address counter, and supports abort and configuration-error reporting.

---
 rtl/weight_feed_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/weight_feed_sequencer.sv
// Weight-feeding microsequencer: issues BRAM reads per filter, then pads the
// weight shift chain with zeros so each filter gets exactly DIM shifts.
module weight_feed_sequencer #(
  parameter int DIM = 16,
  parameter int KW  = 5,
  parameter int NW  = 8,
  parameter int AW  = 10,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [KW-1:0]  kernel_size,
  input  logic [NW-1:0]  num_filters,
  input  logic [AW-1:0]  base_addr,
  input  logic           auto_advance,
  input  logic           advance,
  output logic [DIM-1:0] bram_en,
  output logic [AW-1:0]  weight_addr,
  output logic [DIM-1:0] shift_en,
  output logic           zero_or_data,
  output logic [NW-1:0]  filter_idx,
  output logic           filter_done,
  output logic           busy,
  output logic           done,
  output logic           cfg_err
);

  localparam int CW = $clog2(DIM + 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, ZFILL, WAIT_ADV, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [KW-1:0]   k_r;
  logic [NW-1:0]   n_r;
  logic [NW-1:0]   fidx;
  logic [AW-1:0]   addr;
  logic            auto_r;
  logic            rd;
  logic [LAT-1:0]  vld_pipe;

  logic full, last_rd, last_drain, last_zf, fdone, more;

  always_comb begin
    full       = (k_r == KW'(DIM));
    last_rd    = (cnt == CW'(k_r) - CW'(1));
    last_drain = (cnt == CW'(LAT - 1));
    last_zf    = (cnt == CW'(DIM) - CW'(k_r) - CW'(1));
    // DIM-th shift lands in ZFILL, or in the last DRAIN cycle when K fills the row
    fdone      = (state == ZFILL && last_zf) ||
                 (state == DRAIN && last_drain && full);
    more       = (fidx != n_r - NW'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      k_r      <= '0;
      n_r      <= '0;
      fidx     <= '0;
      addr     <= '0;
      auto_r   <= 1'b0;
      rd       <= 1'b0;
      vld_pipe <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err  <= 1'b0;
      done     <= 1'b0;
      vld_pipe <= LAT'({vld_pipe, rd});
      case (state)
        IDLE: if (start) begin
          if (kernel_size == '0 || kernel_size > KW'(DIM) || num_filters == '0) begin
            cfg_err <= 1'b1;
          end else begin
            k_r    <= kernel_size;
            n_r    <= num_filters;
            auto_r <= auto_advance;
            addr   <= base_addr;
            fidx   <= '0;
            cnt    <= '0;
            rd     <= 1'b1;
            busy   <= 1'b1;
            state  <= READ;
          end
        end
        // addr runs on across filters, so it already points at the next filter's word 0
        READ: begin
          addr <= addr + AW'(1);
          if (last_rd) begin
            rd    <= 1'b0;
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRAIN: if (last_drain) begin
          cnt <= '0;
          if (!full) state <= ZFILL;
        end else begin
          cnt <= cnt + CW'(1);
        end
        ZFILL: cnt <= cnt + CW'(1);
        WAIT_ADV: if (advance) begin
          fidx  <= fidx + NW'(1);
          cnt   <= '0;
          rd    <= 1'b1;
          state <= READ;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (fdone) begin
        cnt <= '0;
        if (!more) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FIN;
        end else if (auto_r || advance) begin
          fidx  <= fidx + NW'(1);
          rd    <= 1'b1;
          state <= READ;
        end else begin
          state <= WAIT_ADV;
        end
      end

      // abort overrides everything above, including a same-cycle advance
      if (abort && state != IDLE) begin
        state    <= IDLE;
        rd       <= 1'b0;
        vld_pipe <= '0;
        cnt      <= '0;
        busy     <= 1'b0;
        done     <= 1'b0;
      end
    end
  end

  assign bram_en      = {DIM{rd}};
  assign weight_addr  = addr;
  assign shift_en     = {DIM{vld_pipe[LAT-1] | (state == ZFILL)}};
  assign zero_or_data = (state != ZFILL);
  assign filter_idx   = fidx;
  assign filter_done  = fdone;

endmodule
